// File: rtl/sram_ctl.sv
// sram_ctl: single-port synchronous SRAM with a clear sequencer and a
// req/ready/rvalid handshake. After reset, and on every clr request, the
// whole array is swept to CLR_VAL before accesses are accepted.
// Optional feature macro: SRAM_PARITY_EN adds one parity bit per word,
// parity error injection via par_inv, and the perr read flag.
module sram_ctl #(
  parameter int                 DATA_W  = 16,
  parameter int                 ADDR_W  = 5,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  input  logic              par_inv,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] data_out,
  output logic              perr
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   cnt_r;
  logic                ready_r;
  logic                rvalid_r;
  logic [DATA_W-1:0]   data_out_r;
  logic                perr_r;

  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                acc_s;
  logic                wr_s;
  logic                rd_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;

`ifdef SRAM_PARITY_EN
  logic                par_mem_r [DEPTH];
  logic                mem_wpar_s;

  // Even parity of a data word (XOR reduction).
  function automatic logic parity_f(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`else
  // par_inv has no function without parity storage.
  logic                unused_par_inv_s;
  assign unused_par_inv_s = par_inv;
`endif

  assign ready    = ready_r;
  assign rvalid   = rvalid_r;
  assign data_out = data_out_r;
  assign perr     = perr_r;

  // Access acceptance: clr has priority over req, and nothing is taken while sweeping.
  always_comb begin
    acc_s = 1'b0;
    wr_s  = 1'b0;
    rd_s  = 1'b0;
    if ((state_r == ST_READY) && ready_r && req && !clr) begin
      acc_s = 1'b1;
      wr_s  = !we_n;
      rd_s  = we_n;
    end else begin
      acc_s = 1'b0;
    end
  end

  // Array write port mux: the sweep owns the port while clearing, the requester otherwise.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = addr;
    mem_wdata_s = data_in;
`ifdef SRAM_PARITY_EN
    mem_wpar_s  = parity_f(data_in) ^ par_inv;
`endif
    if (state_r == ST_SWEEP) begin
      mem_we_s    = 1'b1;
      mem_addr_s  = cnt_r;
      mem_wdata_s = CLR_VAL;
`ifdef SRAM_PARITY_EN
      mem_wpar_s  = parity_f(CLR_VAL);
`endif
    end else begin
      mem_we_s    = wr_s;
    end
  end

  // Storage array write; contents are deliberately not reset (the sweep clears them).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
`ifdef SRAM_PARITY_EN
      par_mem_r[mem_addr_s] <= mem_wpar_s;
`endif
    end
  end

  // Control FSM plus registered read data, rvalid pulse and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_SWEEP;
      cnt_r      <= CNT_ZERO;
      ready_r    <= 1'b0;
      rvalid_r   <= 1'b0;
      data_out_r <= {DATA_W{1'b0}};
      perr_r     <= 1'b0;
    end else begin
      rvalid_r <= rd_s;
      if (rd_s) begin
        data_out_r <= mem_r[addr];
`ifdef SRAM_PARITY_EN
        perr_r     <= parity_f(mem_r[addr]) ^ par_mem_r[addr];
`else
        perr_r     <= 1'b0;
`endif
      end
      case (state_r)
        ST_SWEEP: begin
          cnt_r <= cnt_r + ADDR_W'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end else begin
            state_r <= ST_SWEEP;
            ready_r <= 1'b0;
          end
        end
        ST_READY: begin
          if (clr) begin
            state_r <= ST_SWEEP;
            cnt_r   <= CNT_ZERO;
            ready_r <= 1'b0;
          end else begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_SWEEP;
          cnt_r   <= CNT_ZERO;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctl.sv
// tb_sram_ctl: directed bench for sram_ctl with a read scoreboard.
// Read expectations come from a bench-side memory model and are queued at
// issue time; a monitor pops one entry for every rvalid pulse.
module tb_sram_ctl;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we_n;
  logic [4:0]  addr;
  logic [15:0] data_in;
  logic        clr;
  logic        par_inv;
  logic        ready;
  logic        rvalid;
  logic [15:0] data_out;
  logic        perr;

  typedef struct packed {
    logic [15:0] d;
    logic        p;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_m [32];
  logic        par_m [32];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_rd = 0;
  int          n_rv = 0;

  sram_ctl #(.DATA_W(16), .ADDR_W(5), .CLR_VAL(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we_n(we_n), .addr(addr),
    .data_in(data_in), .clr(clr), .par_inv(par_inv), .ready(ready),
    .rvalid(rvalid), .data_out(data_out), .perr(perr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mem_m[i] = 16'h0000;
      par_m[i] = 1'b0;
    end
  endtask

  // Expects to be called just after a rising edge; checks ready across a 32-edge sweep.
  task automatic sweep_check(input string name);
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); #1;
      chk(name, {31'd0, ready}, {31'd0, (i == 32)});
    end
    model_clear();
  endtask

  // One access, accepted at the next rising edge; inputs released 1 after it.
  task automatic op(input logic wr, input logic [4:0] a, input logic [15:0] d, input logic pinv);
    exp_t e;
    chk("ready_at_op", {31'd0, ready}, 32'd1);
    req = 1'b1; we_n = ~wr; addr = a; data_in = d; par_inv = pinv;
    if (wr) begin
      mem_m[a] = d;
      par_m[a] = pinv;
    end else begin
      e.d = mem_m[a];
`ifdef SRAM_PARITY_EN
      e.p = par_m[a];
`else
      e.p = 1'b0;
`endif
      exp_q.push_back(e);
      n_rd++;
    end
    @(posedge clk); #1;
    req = 1'b0; we_n = 1'b1; par_inv = 1'b0;
  endtask

  // Scoreboard monitor: every rvalid pulse must match the oldest queued read.
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      exp_t e;
      n_rv++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got data %h with no read pending", data_out);
      end else begin
        e = exp_q.pop_front();
        chk("read_data", {16'd0, data_out}, {16'd0, e.d});
        chk("read_perr", {31'd0, perr}, {31'd0, e.p});
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we_n = 1'b1; addr = 5'd0;
    data_in = 16'h0000; clr = 1'b0; par_inv = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_data_out", {16'd0, data_out}, 32'd0);
    chk("rst_perr", {31'd0, perr}, 32'd0);
    rst_n = 1'b1;
    sweep_check("rst_sweep_ready");

    // Cleared contents at low, middle and top addresses.
    op(1'b0, 5'd0, 16'h0, 1'b0);
    op(1'b0, 5'd17, 16'h0, 1'b0);
    op(1'b0, 5'd31, 16'h0, 1'b0);

    // Write then read next cycle, then data_out holds while idle.
    op(1'b1, 5'd5, 16'hBEEF, 1'b0);
    op(1'b0, 5'd5, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_data_out", {16'd0, data_out}, 32'h0000BEEF);
      chk("hold_rvalid_low", {31'd0, rvalid}, 32'd0);
    end

    // Back-to-back writes and reads.
    op(1'b1, 5'd1, 16'h1111, 1'b0);
    op(1'b1, 5'd2, 16'h2222, 1'b0);
    op(1'b0, 5'd1, 16'h0, 1'b0);
    op(1'b0, 5'd2, 16'h0, 1'b0);
    @(posedge clk); #1;

    // clr together with a write: write dropped, 32-edge sweep.
    chk("ready_before_clr", {31'd0, ready}, 32'd1);
    clr = 1'b1; req = 1'b1; we_n = 1'b0; addr = 5'd3; data_in = 16'hAAAA;
    @(posedge clk); #1;
    clr = 1'b0; req = 1'b0; we_n = 1'b1;
    chk("clr_ready_drop", {31'd0, ready}, 32'd0);
    sweep_check("clr_sweep_ready");
    op(1'b0, 5'd3, 16'h0, 1'b0);
    op(1'b0, 5'd5, 16'h0, 1'b0);
    chk("data_out_after_clr_reads", {16'd0, data_out}, 32'h00000000);

    // Reset asserted at the tenth sweep edge restarts the sweep.
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midsweep_rst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b1;
    sweep_check("midsweep_ready");

    // Parity injection and clean parity.
    op(1'b1, 5'd7, 16'h0001, 1'b1);
    op(1'b0, 5'd7, 16'h0, 1'b0);
    op(1'b1, 5'd7, 16'h0001, 1'b0);
    op(1'b0, 5'd7, 16'h0, 1'b0);
    op(1'b1, 5'd9, 16'h5A5A, 1'b0);
    op(1'b0, 5'd9, 16'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("rvalid_count", n_rv, n_rd);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctl.md
# sram_ctl

Parametrised single-port synchronous SRAM with a built-in clear sequencer and a req/ready/rvalid handshake. It replaces the fixed 16x32 program/data store of the Mano machine. It auto-clears its contents after reset and on demand. It optionally protects each word with a parity bit.

## Interface
- `DATA_W`, default 16: word width in bits, ≥1.
- `ADDR_W`, default 5: address width; depth is 2^ADDR_W words.
- `CLR_VAL`, default 0: `DATA_W`-bit value written to every word by a clear sweep.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  1  access request; sampled when `ready`=1.
- `we_n`  in  1  0 = write, 1 = read; qualifies `req`.
- `addr`  in  `ADDR_W`  word address.
- `data_in`  in  `DATA_W`  write data.
- `clr`  in  1  single-cycle request to clear the whole array.
- `par_inv`  in  1  error injection: with a write, store inverted parity (parity build only).
- `ready`  out  1  1 = an access can be accepted this cycle.
- `rvalid`  out  1  one-cycle pulse: `data_out` holds new read data.
- `data_out`  out  `DATA_W`  registered read data; holds until the next read completes.
- `perr`  out  1  parity error, valid with `rvalid`.

## Operation
- **States:** `SWEEP` (clear in progress) and `READY`. Sweep counter `cnt` is `ADDR_W` bits.
- **Reset (async, `rst_n`=0):**
  - state=`SWEEP`, `cnt`=0.
  - `ready`=0, `rvalid`=0, `data_out`=0, `perr`=0.
  - Array contents are not reset; the sweep clears them.
- **`SWEEP` state:**
  - Each edge writes `CLR_VAL` to `mem[cnt]` and increments `cnt`.
  - On the edge that writes address 2^ADDR_W−1: `cnt` wraps to 0 and state becomes `READY`.
  - `req` and `clr` are ignored.
- **`READY` state:**
  - `ready` = 1 (registered: `ready` = state==`READY`).
  - An access is accepted iff `req` && `ready` && !`clr`.
  - `clr`=1 wins over `req`: enter `SWEEP` with `cnt`=0. The `req` is dropped; the requester must re-issue it.
- **Write** (accepted, `we_n`=0): `mem[addr]` ← `data_in` at the accepting edge. No `rvalid`.
- **Read** (accepted, `we_n`=1):
  - At the accepting edge: `data_out` ← `mem[addr]` and `rvalid` ← 1.
  - `rvalid` returns to 0 on the next edge unless another read is accepted.
- **Back-to-back:** accesses may be accepted on every cycle.
  - A read following a write to the same address on the next cycle returns the new data.
  - One access per cycle, so there is no same-cycle read/write.
- **Reset mid-operation:** asserting `rst_n` during a sweep or a read restarts the sweep from address 0. The pending `rvalid` is lost.
- **`addr` width:** `addr` is exactly `ADDR_W`, so there are no out-of-range addresses.

## Timing
- **Sweep length:** 2^ADDR_W edges. The first edge with `rst_n`=1 clears address 0.
  - `ready` rises after edge 2^ADDR_W; with defaults that is after edge 32.
  - The first access can be accepted at edge 33.
- **Read latency:** 1 cycle, request edge to `rvalid`/`data_out`.
- **Clear latency:** a `clr` accepted at edge k drops `ready` after edge k. `ready` is high again after edge k+2^ADDR_W.
- **`data_out`:** unchanged by writes, by sweeps and by `rvalid` falling.

## Configuration
- **`SRAM_PARITY_EN` defined:**
  - Each word is `DATA_W`+1 bits; the extra bit is ^`data_in`, inverted when `par_inv`=1.
  - The sweep stores the correct parity of `CLR_VAL`.
  - A read sets `perr` ← (^stored_data) ≠ stored_parity, registered alongside `data_out`.
  - `perr` stays valid while `rvalid`=1 and is held like `data_out`.
- **`SRAM_PARITY_EN` not defined:**
  - No parity storage.
  - `perr` is constant 0 and `par_inv` is ignored.

## Test plan
- **Reset sweep:** pulse `rst_n` low, run 33 edges.
  - `ready`=0 through edge 32 and 1 after it.
  - Reads of addresses 0, 17 and 31 all return `CLR_VAL`=0x0000.
- **Write/read:**
  - Write 0xBEEF to address 5, then read address 5 on the next cycle: `rvalid` one cycle later with `data_out`=0xBEEF.
  - `data_out` stays 0xBEEF for 10 idle cycles.
- **Back-to-back:**
  - Writes of 0x1111 to address 1 and 0x2222 to address 2 on consecutive cycles, then reads of 1 and 2 on consecutive cycles.
  - `rvalid` is high for 2 cycles, with `data_out` 0x1111 then 0x2222.
- **`clr` with `req`:**
  - In `READY`, assert `clr` and a write of 0xAAAA to address 3 in the same cycle: the write is dropped and `ready` goes low for 32 cycles.
  - A subsequent read of address 3 returns 0x0000.
- **Reset mid-sweep:** assert `rst_n` low at sweep edge 10.
  - `ready` stays 0 and rises exactly 32 edges after release.
- **Parity (`SRAM_PARITY_EN`):**
  - Write 0x0001 to address 7 with `par_inv`=1, then read address 7: `perr`=1 with `rvalid`.
  - The same write with `par_inv`=0 gives `perr`=0.
  - In the non-parity build `perr` stays 0 throughout.
